// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: round-robin arbitration, base/mask decode, decode-error response.
// Define WB_BUS_TIMEOUT_EN to enable the stalled-strobe timeout watchdog.
module wb_shared_bus #(
    parameter int unsigned                  NUM_MASTERS = 2,
    parameter int unsigned                  NUM_SLAVES  = 4,
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_BASE  = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]     SLAVE_MASK  = {NUM_SLAVES{32'hFFFFFFFF}},
    parameter int unsigned                  TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [32*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [4*NUM_MASTERS-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [31:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [31:0]                 s_adr_o,
    output logic [31:0]                 s_dat_o,
    output logic [3:0]                  s_sel_o,
    output logic                        s_we_o,
    output logic [NUM_SLAVES-1:0]       s_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    input  logic [32*NUM_SLAVES-1:0]    s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_err_i,
    input  logic [NUM_SLAVES-1:0]       s_rty_i,
    output logic [NUM_MASTERS-1:0]      gnt_o,
    output logic                        bus_err_o,
    output logic [31:0]                 err_adr_o
);

    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [NUM_MASTERS-1:0]  gnt, gnt_nxt, req_other;
    logic [IW-1:0]           last, last_nxt, g_idx;
    logic                    busy, g_cyc, g_stb;
    logic [NUM_SLAVES-1:0]   sel;
    logic                    any_hit, sel_ack, sel_err, sel_rty, slv_resp;
    logic                    err_pend, dec_err, tmo;

    // First requester strictly after 'from', wrapping, so 'from' itself is checked last.
    function automatic logic [NUM_MASTERS-1:0] rr_pick(input logic [IW-1:0] from,
                                                       input logic [NUM_MASTERS-1:0] req);
        logic [NUM_MASTERS-1:0] pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = (32'(from) + k) % NUM_MASTERS;
            if (pick == '0 && req[idx]) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    assign busy      = (state == BUSY);
    assign gnt_o     = gnt;
    assign req_other = m_cyc_i & ~gnt;

    always_comb begin
        g_idx = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++)
            if (gnt[k]) g_idx = IW'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(NUM_MASTERS - 1);
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    gnt_nxt   = rr_pick(last, m_cyc_i);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    last_nxt  = g_idx;
                    gnt_nxt   = rr_pick(g_idx, req_other);
                    state_nxt = (|req_other) ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        g_cyc   = 1'b0;
        g_stb   = 1'b0;
        if (busy) begin
            s_adr_o = m_adr_i[32*g_idx +: 32];
            s_dat_o = m_dat_i[32*g_idx +: 32];
            s_sel_o = m_sel_i[4*g_idx +: 4];
            s_we_o  = m_we_i[g_idx];
            g_cyc   = m_cyc_i[g_idx];
            g_stb   = m_cyc_i[g_idx] & m_stb_i[g_idx];
        end
    end

    // Lowest matching slave index wins when windows overlap.
    always_comb begin
        sel     = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit && ((s_adr_o & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                sel[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
        if (!busy) begin
            sel     = '0;
            any_hit = 1'b0;
        end
    end

    always_comb begin
        m_dat_o = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++)
            if (sel[i]) m_dat_o = s_dat_i[32*i +: 32];
    end

    assign sel_ack  = |(sel & s_ack_i);
    assign sel_err  = |(sel & s_err_i);
    assign sel_rty  = |(sel & s_rty_i);
    assign slv_resp = sel_ack | sel_err | sel_rty;

`ifdef WB_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_cnt;

    // Fires on the TIMEOUT_CYC-th consecutive stalled cycle of a mapped strobe.
    assign tmo = g_stb && any_hit && !slv_resp && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || !g_stb || !any_hit || slv_resp || tmo) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    assign dec_err = g_stb && !any_hit && !err_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend  <= 1'b0;
            err_adr_o <= '0;
        end else begin
            err_pend <= dec_err;
            if (dec_err || tmo) err_adr_o <= s_adr_o;
        end
    end

    assign s_cyc_o   = (g_cyc && !tmo) ? sel : '0;
    assign s_stb_o   = (g_stb && !tmo) ? sel : '0;
    assign m_ack_o   = sel_ack ? gnt : '0;
    assign m_rty_o   = sel_rty ? gnt : '0;
    assign m_err_o   = (sel_err || err_pend || tmo) ? gnt : '0;
    assign bus_err_o = err_pend | tmo;

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: directed scenarios plus randomized transactions vs. a reference model.
module tb_wb_shared_bus;

    localparam int unsigned NM  = 2;
    localparam int unsigned NS  = 3;
    localparam int unsigned TMO = 8;
    localparam logic [32*NS-1:0] BASE = {32'h4000_0000, 32'hF000_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic               clk = 1'b0;
    logic               rst;
    logic [32*NM-1:0]   m_adr_i, m_dat_i;
    logic [4*NM-1:0]    m_sel_i;
    logic [NM-1:0]      m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]        m_dat_o;
    logic [NM-1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [31:0]        s_adr_o, s_dat_o;
    logic [3:0]         s_sel_o;
    logic               s_we_o;
    logic [NS-1:0]      s_cyc_o, s_stb_o;
    logic [32*NS-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i, s_err_i, s_rty_i;
    logic [NM-1:0]      gnt_o;
    logic               bus_err_o;
    logic [31:0]        err_adr_o;

    wb_shared_bus #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .bus_err_o(bus_err_o), .err_adr_o(err_adr_o)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address map written out from the memory map, not from the flat parameter vectors.
    function automatic int exp_slave(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        if (a[31:16] == 16'hF000) return 1;
        if (a[31:28] == 4'h4)     return 2;
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int i);
        return (i < 0) ? 32'd0 : (32'd1 << i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic mdrive(input int m, input logic cyc, input logic [31:0] adr,
                          input logic we, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc_i[m]          = cyc;
        m_stb_i[m]          = cyc;
        m_adr_i[32*m +: 32] = adr;
        m_dat_i[32*m +: 32] = dat;
        m_sel_i[4*m +: 4]   = sel;
        m_we_i[m]           = we;
    endtask

    task automatic sclear();
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
    endtask

    task automatic sresp(input int s, input int kind, input logic [31:0] d);
        s_ack_i[s]          = (kind == 0);
        s_err_i[s]          = (kind == 1);
        s_rty_i[s]          = (kind == 2);
        s_dat_i[32*s +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
        s_dat_i = '0;
        sclear();
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return {16'h0000, r[15:0]};
            1:       return {16'hF000, r[15:0]};
            2:       return {4'h4, r[27:0]};
            3:       return {4'h8, r[27:0]};
            default: return {16'h0001, r[15:0]};
        endcase
    endfunction

    logic [31:0] r_adr [NM];
    logic [31:0] r_dat [NM];
    logic [3:0]  r_sel [NM];
    logic        r_we  [NM];

    // Entered just after the edge that grants master m; leaves after the edge that releases it.
    task automatic run_txn(input int m);
        int s, lat, kind;
        logic [31:0] sd [NS];
        s = exp_slave(r_adr[m]);
        look();
        chk("rnd_gnt", 32'(gnt_o), oh(m));
        chk("rnd_adr", s_adr_o, r_adr[m]);
        chk("rnd_wdat", s_dat_o, r_dat[m]);
        chk("rnd_sel", 32'(s_sel_o), 32'(r_sel[m]));
        chk("rnd_we", 32'(s_we_o), 32'(r_we[m]));
        chk("rnd_stb", 32'(s_stb_o), oh(s));
        if (s < 0) begin
            chk("rnd_noerr_yet", 32'(m_err_o), 32'd0);
            step();
            look();
            chk("rnd_decerr", 32'(m_err_o), oh(m));
            chk("rnd_buserr", 32'(bus_err_o), 32'd1);
            chk("rnd_erradr", err_adr_o, r_adr[m]);
            step();
        end else begin
            lat = $urandom_range(0, 2);
            chk("rnd_stall", 32'({m_ack_o, m_err_o, m_rty_o}), 32'd0);
            for (int i = 0; i < lat; i++) begin
                step();
                look();
                chk("rnd_stall", 32'({m_ack_o, m_err_o, m_rty_o}), 32'd0);
            end
            step();
            kind = $urandom_range(0, 2);
            for (int j = 0; j < int'(NS); j++) begin
                sd[j] = $urandom;
                s_dat_i[32*j +: 32] = sd[j];
            end
            sresp(s, kind, sd[s]);
            look();
            chk("rnd_ack", 32'(m_ack_o), (kind == 0) ? oh(m) : 32'd0);
            chk("rnd_err", 32'(m_err_o), (kind == 1) ? oh(m) : 32'd0);
            chk("rnd_rty", 32'(m_rty_o), (kind == 2) ? oh(m) : 32'd0);
            chk("rnd_rdat", m_dat_o, sd[s]);
            chk("rnd_nobuserr", 32'(bus_err_o), 32'd0);
            step();
            sclear();
        end
        mdrive(m, 1'b0, '0, 1'b0, '0, '0);
        look();
        step();
    endtask

    initial begin
        int last, first, other;
        logic [1:0] req;

        // Reset
        do_reset();
        look();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_scyc", 32'(s_cyc_o), 32'd0);
        chk("rst_buserr", 32'(bus_err_o), 32'd0);
        chk("rst_erradr", err_adr_o, 32'd0);
        chk("rst_mresp", 32'({m_ack_o, m_err_o, m_rty_o}), 32'd0);
        step();

        // Single read from S0
        mdrive(0, 1'b1, 32'h0000_0010, 1'b0, '0, 4'hF);
        look();
        chk("rd_gnt_lat", 32'(gnt_o), 32'd0);
        chk("rd_stb_lat", 32'(s_stb_o), 32'd0);
        step();
        look();
        chk("rd_gnt", 32'(gnt_o), 32'h1);
        chk("rd_stb", 32'(s_stb_o), 32'h1);
        chk("rd_adr", s_adr_o, 32'h0000_0010);
        chk("rd_noack", 32'(m_ack_o), 32'd0);
        step();
        look();
        chk("rd_noack2", 32'(m_ack_o), 32'd0);
        step();
        sresp(0, 0, 32'hDEAD_BEEF);
        look();
        chk("rd_ack", 32'(m_ack_o), 32'h1);
        chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
        step();
        sclear();
        mdrive(0, 1'b0, '0, 1'b0, '0, '0);
        look();
        chk("rd_cyc_drop", 32'(s_cyc_o), 32'd0);
        step();
        look();
        chk("rd_idle", 32'(gnt_o), 32'd0);
        step();

        // Contention from reset: M0 first, M1 takes over on the release edge
        do_reset();
        mdrive(0, 1'b1, 32'h0000_0100, 1'b0, '0, 4'hF);
        mdrive(1, 1'b1, 32'h4000_0020, 1'b1, 32'h1234_5678, 4'h3);
        look();
        chk("ct_gnt_lat", 32'(gnt_o), 32'd0);
        step();
        look();
        chk("ct_gnt_m0", 32'(gnt_o), 32'h1);
        chk("ct_stb_s0", 32'(s_stb_o), 32'h1);
        step();
        sresp(0, 0, 32'hAAAA_0000);
        look();
        chk("ct_ack_m0", 32'(m_ack_o), 32'h1);
        step();
        sclear();
        mdrive(0, 1'b0, '0, 1'b0, '0, '0);
        look();
        chk("ct_hold", 32'(gnt_o), 32'h1);
        step();
        look();
        chk("ct_gnt_m1", 32'(gnt_o), 32'h2);
        chk("ct_stb_s2", 32'(s_stb_o), 32'h4);
        chk("ct_wdat", s_dat_o, 32'h1234_5678);
        chk("ct_we", 32'(s_we_o), 32'd1);
        step();
        sresp(2, 0, 32'h5555_AAAA);
        look();
        chk("ct_ack_m1", 32'(m_ack_o), 32'h2);
        step();
        sclear();
        mdrive(1, 1'b0, '0, 1'b0, '0, '0);
        look();
        step();
        look();
        chk("ct_idle", 32'(gnt_o), 32'd0);
        step();

        // Decode error: M1 writes an unmapped address
        mdrive(1, 1'b1, 32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF);
        look();
        step();
        look();
        chk("de_gnt", 32'(gnt_o), 32'h2);
        chk("de_scyc", 32'(s_cyc_o), 32'd0);
        chk("de_noerr", 32'(m_err_o), 32'd0);
        step();
        look();
        chk("de_err", 32'(m_err_o), 32'h2);
        chk("de_buserr", 32'(bus_err_o), 32'd1);
        chk("de_erradr", err_adr_o, 32'h8000_0000);
        step();
        look();
        chk("de_err_clr", 32'(m_err_o), 32'd0);
        chk("de_buserr_clr", 32'(bus_err_o), 32'd0);
        step();
        look();
        chk("de_err_again", 32'(m_err_o), 32'h2);
        step();
        mdrive(1, 1'b0, '0, 1'b0, '0, '0);
        look();
        chk("de_drop_noerr", 32'(m_err_o), 32'd0);
        step();

        // Overlap priority / window selection
        mdrive(0, 1'b1, 32'h4000_0000, 1'b0, '0, 4'hF);
        look();
        step();
        look();
        chk("ov_gnt", 32'(gnt_o), 32'h1);
        chk("ov_stb_s2", 32'(s_stb_o), 32'h4);
        step();
        sresp(2, 0, 32'h0000_0042);
        look();
        chk("ov_ack", 32'(m_ack_o), 32'h1);
        step();
        sclear();
        mdrive(0, 1'b1, 32'h0000_1234, 1'b0, '0, 4'hF);
        look();
        chk("ov_stb_s0", 32'(s_stb_o), 32'h1);
        step();
        mdrive(0, 1'b0, '0, 1'b0, '0, '0);
        look();
        step();

        // Stalled slave
        mdrive(0, 1'b1, 32'hF000_0004, 1'b0, '0, 4'hF);
        look();
        step();
`ifdef WB_BUS_TIMEOUT_EN
        for (int k = 1; k < int'(TMO); k++) begin
            look();
            chk("to_stall_stb", 32'(s_stb_o), 32'h2);
            chk("to_stall_err", 32'(m_err_o), 32'd0);
            step();
        end
        look();
        chk("to_stb_forced", 32'(s_stb_o), 32'd0);
        chk("to_err", 32'(m_err_o), 32'h1);
        chk("to_buserr", 32'(bus_err_o), 32'd1);
        step();
        look();
        chk("to_erradr", err_adr_o, 32'hF000_0004);
        chk("to_stb_back", 32'(s_stb_o), 32'h2);
        chk("to_buserr_clr", 32'(bus_err_o), 32'd0);
        step();
`else
        for (int k = 1; k <= 12; k++) begin
            look();
            chk("hang_stb", 32'(s_stb_o), 32'h2);
            chk("hang_noerr", 32'({m_err_o, bus_err_o}), 32'd0);
            step();
        end
`endif
        mdrive(0, 1'b0, '0, 1'b0, '0, '0);
        look();
        step();

        // Randomized traffic against the round-robin/decode model
        do_reset();
        last = int'(NM) - 1;
        for (int round = 0; round < 60; round++) begin
            req = 2'($urandom_range(1, 3));
            for (int m = 0; m < int'(NM); m++) begin
                if (req[m]) begin
                    r_adr[m] = rand_addr();
                    r_dat[m] = $urandom;
                    r_sel[m] = 4'($urandom);
                    r_we[m]  = 1'($urandom);
                    mdrive(m, 1'b1, r_adr[m], r_we[m], r_dat[m], r_sel[m]);
                end
            end
            first = (req[(last + 1) % int'(NM)]) ? (last + 1) % int'(NM) : last;
            other = (first + 1) % int'(NM);
            look();
            chk("rnd_idle_gnt", 32'(gnt_o), 32'd0);
            step();
            run_txn(first);
            last = first;
            if (req[other]) begin
                run_txn(other);
                last = other;
            end
            look();
            chk("rnd_back_idle", 32'(gnt_o), 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_shared_bus.md
Name: wb_shared_bus

Overview:
Parametrised Wishbone shared-bus interconnect with NUM_MASTERS masters and NUM_SLAVES slaves.
- Round-robin arbitration, held for the whole granted cycle.
- Programmable base/mask address decode.
- Error response for unmapped addresses.
- Optional bus-timeout watchdog.
Sits between the LM32 I/D ports (plus future DMA masters) and the memory and peripheral slaves, replacing the fixed 8x8 crossbar.

Parameters:
NUM_MASTERS, 2, number of master ports (1..8)
NUM_SLAVES, 4, number of slave ports (1..16)
SLAVE_BASE, {NUM_SLAVES{32'h0}}, flat vector of slave base addresses; slave i at bits [32*i+31:32*i]
SLAVE_MASK, {NUM_SLAVES{32'hFFFFFFFF}}, flat vector of decode masks, same packing
TIMEOUT_CYC, 255, stalled-strobe cycles before timeout error (8-bit counter, 1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m_adr_i  in  32*NUM_MASTERS  master addresses (master k at [32k+31:32k])
m_dat_i  in  32*NUM_MASTERS  master write data
m_sel_i  in  4*NUM_MASTERS  master byte selects
m_we_i  in  NUM_MASTERS  master write enables
m_cyc_i  in  NUM_MASTERS  master cycle
m_stb_i  in  NUM_MASTERS  master strobe
m_dat_o  out  32  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master error
m_rty_o  out  NUM_MASTERS  per-master retry
s_adr_o  out  32  address, broadcast to all slaves
s_dat_o  out  32  write data, broadcast
s_sel_o  out  4  byte selects, broadcast
s_we_o  out  1  write enable, broadcast
s_cyc_o  out  NUM_SLAVES  per-slave cycle, decoded
s_stb_o  out  NUM_SLAVES  per-slave strobe, decoded
s_dat_i  in  32*NUM_SLAVES  slave read data
s_ack_i  in  NUM_SLAVES  slave ack
s_err_i  in  NUM_SLAVES  slave error
s_rty_i  in  NUM_SLAVES  slave retry
gnt_o  out  NUM_MASTERS  one-hot current grant, all-zero when idle
bus_err_o  out  1  one-cycle pulse on a decode or timeout error
err_adr_o  out  32  address captured at the most recent bus_err_o

Behaviour:
- Reset: state IDLE, gnt_o=0, last-grant pointer=NUM_MASTERS-1. All m_ack/err/rty, s_cyc/s_stb and bus_err_o are 0. err_adr_o=0. Timeout counter=0.
- FSM IDLE:
  - If any m_cyc_i is high, register a grant to the first requester searching from (last+1) mod NUM_MASTERS upward with wrap; go to BUSY.
  - Grant latency is 1 cycle: master cyc at edge n, slave sees stb after edge n+1.
- FSM BUSY:
  - Grant held while the granted m_cyc_i stays high; lock is implied by cyc.
  - When the granted cyc drops, update last and re-arbitrate on the same edge among requesters other than the leaving one. If none, go to IDLE with gnt_o=0.
  - A master that drops and immediately reasserts cyc waits for one full round.
- Datapath (combinational from the registered grant): s_adr/s_dat/s_sel/s_we come from the granted master; all zeros when idle.
- Decode:
  - hit_i = ((s_adr_o & MASK_i) == BASE_i).
  - The lowest matching index wins; one-hot sel.
  - s_cyc_o[i] = granted cyc & sel_i; s_stb_o[i] = granted stb & sel_i.
- Response routing:
  - m_dat_o = s_dat_i of the selected slave (0 if none).
  - ack/err/rty of the selected slave go to the granted master only; non-granted masters see 0.
- Decode error:
  - Granted stb high, no hit, and err_pend=0: err_pend is set at the next edge.
  - err_pend drives m_err_o of the granted master for exactly 1 cycle, then clears, even if stb stays high.
  - bus_err_o pulses in the same cycle; err_adr_o latches the address.
  - A new unmapped strobe after err_pend clears errors again, giving at most one error every 2 cycles.
- Simultaneous events:
  - Slave ack/err/rty are passed through unchanged.
  - An internal error is never generated in a cycle where the selected slave responds.
- Reset mid-cycle: all outputs return to reset values at the next edge; in-flight transfers are dropped without a response.

Optional Feature:
WB_BUS_TIMEOUT_EN defined:
- 8-bit counter clears whenever the granted stb is low or any response is seen; otherwise it increments.
- On reaching TIMEOUT_CYC it issues a 1-cycle err to the granted master.
- The same cycle forces the decoded s_cyc_o/s_stb_o to 0, pulses bus_err_o and latches err_adr_o; the counter then clears.

Undefined: no counter logic; a stalled slave hangs the bus indefinitely.

Test Plan:
Config: NUM_MASTERS=2, NUM_SLAVES=3; S0 base 0x00000000/mask 0xFFFF0000; S1 base 0xF0000000/mask 0xFFFF0000; S2 base 0x40000000/mask 0xF0000000.
- Reset: rst=1 for 2 cycles -> gnt_o=0, s_cyc_o=0, bus_err_o=0, err_adr_o=0.
- Single read: M0 reads 0x00000010, S0 acks after 2 cycles with data 0xDEADBEEF -> gnt_o=01 after 1 cycle; s_stb_o=001; m_ack_o=01; m_dat_o=0xDEADBEEF.
- Contention: M0 and M1 assert cyc in the same cycle from reset -> M0 granted first; after M0 drops cyc, M1 is granted on the same edge with gnt_o=10 and no idle cycle.
- Decode error: M1 writes 0x80000000 -> s_cyc_o=000; m_err_o=10 for exactly 1 cycle; bus_err_o pulses; err_adr_o=0x80000000.
- Overlap priority: M0 accesses 0x40000000 (matches S2 only) -> s_stb_o=100. A 0x0000xxxx access selects S0, not S2.
- Timeout (WB_BUS_TIMEOUT_EN, TIMEOUT_CYC=8): S1 never acks for M0 access 0xF0000004 -> err on the 8th stalled cycle; s_stb_o is forced to 0 in that cycle; err_adr_o=0xF0000004.
